// File: rtl/coprocessor_memory_pipelined.sv
// Purpose: on-chip word RAM behind an Avalon-MM slave port. It has a selectable
// read latency, a hardware bulk-clear engine and out-of-range detection.
// Ports:
//   clk, reset_n        clock and asynchronous active-low reset
//   address..writedata  Avalon-MM request (word address, byte enables)
//   readdata(valid)     read response, one valid pulse per accepted read
//   waitrequest         stall; a transfer is accepted only while low
//   clken               global clock enable; low freezes all state
//   clear_req           level request to clear the whole array
//   clear_busy/done     clear engine status and completion pulse
//   bus_error           pulse on an out-of-range or read+write access
module coprocessor_memory_pipelined #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 14,
  parameter int unsigned           DEPTH       = 8704,
  parameter int unsigned           OUTPUT_REG  = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  input  logic                    clken,
  input  logic                    clear_req,
  output logic                    clear_busy,
  output logic                    clear_done,
  output logic                    bus_error
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic                    r_clear_busy;
  logic                    r_clear_done;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic                    r_rd_vld;
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic                    r_bus_err;

  logic                    w_stall;
  logic                    w_acc;
  logic                    w_in_range;
  logic                    w_bus_we;
  logic                    w_rd_acc;
  logic                    w_err;
  logic                    w_clr_we;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_vld_out;
  logic [DATA_WIDTH-1:0]   w_data_out;

  // A clear request seen in IDLE already blocks the bus that cycle.
  assign w_stall    = ~clken | r_clear_busy | ((r_state == S_IDLE) & clear_req);
  assign w_acc      = chipselect & (read | write) & ~w_stall;
  assign w_in_range = {1'b0, address} < (ADDR_WIDTH+1)'(DEPTH);
  assign w_bus_we   = w_acc & write & w_in_range;
  assign w_rd_acc   = w_acc & read & ~write;
  assign w_err      = w_acc & (~w_in_range | (read & write));
  assign w_clr_we   = clken & (r_state == S_CLEAR);
  assign w_idx      = IDX_W'(address);

  // Clear-engine FSM with registered status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_clear_busy <= 1'b0;
      r_clear_done <= 1'b0;
    end else if (clken) begin
      case (r_state)
        S_IDLE: begin
          r_clear_done <= 1'b0;
          if (clear_req) begin
            r_state      <= S_CLEAR;
            r_cnt        <= '0;
            r_clear_busy <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (r_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            r_state      <= S_DONE;
            r_clear_busy <= 1'b0;
            r_clear_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + ADDR_WIDTH'(1);
          end
        end
        S_DONE: begin
          r_state      <= S_IDLE;
          r_clear_done <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_clear_busy <= 1'b0;
          r_clear_done <= 1'b0;
        end
      endcase
    end
  end

  // Single write port shared by the clear engine and the bus; contents are never reset.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[IDX_W'(r_cnt)] <= CLEAR_VALUE;
    end else if (w_bus_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (byteenable[i]) r_mem[w_idx][i*8 +: 8] <= writedata[i*8 +: 8];
      end
    end
  end

  // First read stage; out-of-range reads return zero with normal timing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_vld  <= 1'b0;
      r_rd_data <= '0;
      r_bus_err <= 1'b0;
    end else if (clken) begin
      r_rd_vld  <= w_rd_acc;
      r_bus_err <= w_err;
      if (w_rd_acc) r_rd_data <= w_in_range ? r_mem[w_idx] : '0;
    end
  end

  // Optional output register adds one cycle of read latency.
  if (OUTPUT_REG != 0) begin : g_oreg
    logic                  r_vld2;
    logic [DATA_WIDTH-1:0] r_data2;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_vld2  <= 1'b0;
        r_data2 <= '0;
      end else if (clken) begin
        r_vld2 <= r_rd_vld;
        if (r_rd_vld) r_data2 <= r_rd_data;
      end
    end

    assign w_vld_out  = r_vld2;
    assign w_data_out = r_data2;
  end else begin : g_noreg
    assign w_vld_out  = r_rd_vld;
    assign w_data_out = r_rd_data;
  end

  // Pulses are masked while frozen; pending ones surface when clken returns.
  assign readdata      = w_data_out;
  assign readdatavalid = w_vld_out & clken;
  assign waitrequest   = w_stall;
  assign clear_busy    = r_clear_busy;
  assign clear_done    = r_clear_done & clken;
  assign bus_error     = r_bus_err & clken;

endmodule

// File: tb/tb_coprocessor_memory_pipelined.sv
// Bench: two instances share one bus. Instance A uses the defaults
// (DEPTH 8704, latency 1). Instance B uses DEPTH 16, latency 2 and a
// non-zero clear value. A scoreboard monitor checks read data and arrival cycle.
module tb_coprocessor_memory_pipelined;
  localparam logic [31:0] CLR_B = 32'hC1EA_C1EA;

  logic        clk = 1'b0;
  logic        reset_n, chipselect, read, write, clken, clear_req_a, clear_req_b;
  logic [13:0] address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata_a, readdata_b;
  logic        rdv_a, rdv_b, wait_a, wait_b, busy_a, busy_b, done_a, done_b, err_a, err_b;

  coprocessor_memory_pipelined u_dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .byteenable(byteenable), .writedata(writedata),
    .readdata(readdata_a), .readdatavalid(rdv_a), .waitrequest(wait_a),
    .clken(clken), .clear_req(clear_req_a), .clear_busy(busy_a),
    .clear_done(done_a), .bus_error(err_a));

  coprocessor_memory_pipelined #(
    .DATA_WIDTH(32), .ADDR_WIDTH(14), .DEPTH(16), .OUTPUT_REG(1), .CLEAR_VALUE(CLR_B)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .byteenable(byteenable), .writedata(writedata),
    .readdata(readdata_b), .readdatavalid(rdv_b), .waitrequest(wait_b),
    .clken(clken), .clear_req(clear_req_b), .clear_busy(busy_b),
    .clear_done(done_b), .bus_error(err_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] d; int due; } exp_t;
  exp_t        q_a[$];
  exp_t        q_b[$];
  int          n_run = 0;
  int          n_fail = 0;
  logic [31:0] model_a [16];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor: every valid must match the head of its queue in both data and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (rdv_a) begin
        n_run++;
        if (q_a.size() == 0) begin
          n_fail++;
          $display("FAIL rd_a unexpected valid: data %0h cycle %0d", readdata_a, cyc);
        end else begin
          e = q_a.pop_front();
          if (readdata_a !== e.d || cyc != e.due) begin
            n_fail++;
            $display("FAIL rd_a: got %0h @%0d expected %0h @%0d", readdata_a, cyc, e.d, e.due);
          end
        end
      end else if (q_a.size() != 0 && q_a[0].due < cyc) begin
        n_run++; n_fail++;
        $display("FAIL rd_a missing: expected %0h @%0d", q_a[0].d, q_a[0].due);
        void'(q_a.pop_front());
      end
      if (rdv_b) begin
        n_run++;
        if (q_b.size() == 0) begin
          n_fail++;
          $display("FAIL rd_b unexpected valid: data %0h cycle %0d", readdata_b, cyc);
        end else begin
          e = q_b.pop_front();
          if (readdata_b !== e.d || cyc != e.due) begin
            n_fail++;
            $display("FAIL rd_b: got %0h @%0d expected %0h @%0d", readdata_b, cyc, e.d, e.due);
          end
        end
      end else if (q_b.size() != 0 && q_b[0].due < cyc) begin
        n_run++; n_fail++;
        $display("FAIL rd_b missing: expected %0h @%0d", q_b[0].d, q_b[0].due);
        void'(q_b.pop_front());
      end
    end
  end

  // One transfer; reads push expectations (A latency 1, B latency 2, plus dly).
  task automatic xfer(input bit rd, input bit wr, input logic [13:0] a, input logic [3:0] be,
                      input logic [31:0] wd, input logic [31:0] xa, input logic [31:0] xb,
                      input int dly);
    chipselect = 1'b1; read = rd; write = wr; address = a; byteenable = be; writedata = wd;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    if (wr && a < 14'd16)
      for (int i = 0; i < 4; i++) if (be[i]) model_a[a[3:0]][i*8 +: 8] = wd[i*8 +: 8];
    if (rd && !wr) begin
      q_a.push_back('{d: xa, due: cyc + dly});
      q_b.push_back('{d: xb, due: cyc + 1 + dly});
    end
  endtask

  task automatic wr_(input logic [13:0] a, input logic [31:0] d, input logic [3:0] be);
    xfer(1'b0, 1'b1, a, be, d, 32'h0, 32'h0, 0);
  endtask

  task automatic rd_(input logic [13:0] a, input logic [31:0] xa, input logic [31:0] xb);
    xfer(1'b1, 1'b0, a, 4'hF, 32'h0, xa, xb, 0);
  endtask

  task automatic chk_err(input string nm, input logic ea, input logic eb);
    @(negedge clk);
    chk({nm, "_err_a"}, 64'(err_a), 64'(ea));
    chk({nm, "_err_b"}, 64'(err_b), 64'(eb));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbad;
    reset_n = 1'b0; clken = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; byteenable = '0; writedata = '0; clear_req_a = 1'b0; clear_req_b = 1'b0;
    #2;
    chk("reset_a", {readdata_a, rdv_a, wait_a, busy_a, done_a, err_a}, 64'h0);
    chk("reset_b", {readdata_b, rdv_b, wait_b, busy_b, done_b, err_b}, 64'h0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) wr_(14'(i), 32'hA000_0000 + 32'(i), 4'hF);

    // Basic write/read, read immediately after write.
    wr_(14'd5, 32'hDEAD_BEEF, 4'hF);
    rd_(14'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Partial byte enables.
    wr_(14'd6, 32'h1122_3344, 4'hF);
    wr_(14'd6, 32'hAABB_CCDD, 4'h5);
    rd_(14'd6, 32'h11BB_33DD, 32'h11BB_33DD);

    // Back-to-back reads.
    for (int i = 0; i < 4; i++) wr_(14'(i), 32'h10 + 32'(i), 4'hF);
    for (int i = 0; i < 4; i++) rd_(14'(i), 32'h10 + 32'(i), 32'h10 + 32'(i));
    wr_(14'd3, 32'hFFFF_FFFF, 4'h0);
    rd_(14'd3, 32'h13, 32'h13);
    repeat (4) @(posedge clk); #1;

    // Out-of-range accesses.
    xfer(1'b1, 1'b0, 14'd8704, 4'hF, 32'h0, 32'h0, 32'h0, 0);
    chk_err("rd_8704", 1'b1, 1'b1);
    xfer(1'b0, 1'b1, 14'd8704, 4'hF, 32'hBAD0_BAD0, 32'h0, 32'h0, 0);
    chk_err("wr_8704", 1'b1, 1'b1);
    wr_(14'd16, 32'h1616_1616, 4'hF);
    chk_err("wr_16", 1'b0, 1'b1);
    rd_(14'd16, 32'h1616_1616, 32'h0);
    chk_err("rd_16", 1'b0, 1'b1);
    rd_(14'd0, 32'h10, 32'h10);
    chk_err("rd_0", 1'b0, 1'b0);

    // Read and write together: write lands, no valid, error pulse.
    xfer(1'b1, 1'b1, 14'd7, 4'hF, 32'h7777_7777, 32'h0, 32'h0, 0);
    chk_err("rd_wr", 1'b1, 1'b1);
    rd_(14'd7, 32'h7777_7777, 32'h7777_7777);
    repeat (4) @(posedge clk); #1;

    // Clock-enable freeze for three cycles while a read is pending.
    xfer(1'b1, 1'b0, 14'd1, 4'hF, 32'h0, 32'h11, 32'h11, 3);
    clken = 1'b0;
    @(negedge clk);
    chk("wait_clken", {wait_a, wait_b}, 64'h3);
    repeat (3) @(posedge clk);
    #1 clken = 1'b1;
    repeat (5) @(posedge clk); #1;

    // Read accepted just before a clear keeps its pre-clear data.
    xfer(1'b1, 1'b0, 14'd5, 4'hF, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    clear_req_b = 1'b1;
    @(posedge clk); #1 clear_req_b = 1'b0;
    nbad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!(busy_b === 1'b1 && wait_b === 1'b1 && done_b === 1'b0)) nbad++;
      @(posedge clk);
    end
    chk("clear_busy_16", 64'(nbad), 64'h0);
    @(negedge clk);
    chk("clear_done", {done_b, busy_b, wait_b}, 64'h4);
    @(negedge clk);
    chk("clear_done_once", 64'(done_b), 64'h0);
    for (int i = 0; i < 16; i++) rd_(14'(i), model_a[i], CLR_B);
    repeat (4) @(posedge clk); #1;

    // Reset in the middle of a clear, after words 0..6 have been cleared.
    for (int i = 0; i < 16; i++) wr_(14'(i), 32'h5000_0000 + 32'(i), 4'hF);
    clear_req_b = 1'b1;
    @(posedge clk); #1 clear_req_b = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("reset_mid_b", {readdata_b, rdv_b, wait_b, busy_b, done_b, err_b}, 64'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    nbad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_b !== 1'b0 || busy_b !== 1'b0) nbad++;
    end
    chk("no_done_after_reset", 64'(nbad), 64'h0);
    for (int i = 0; i < 16; i++)
      rd_(14'(i), 32'h5000_0000 + 32'(i), (i < 7) ? CLR_B : 32'h5000_0000 + 32'(i));
    repeat (6) @(posedge clk); #1;
    chk("queues_drained", 64'(q_a.size() + q_b.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
